// File: rtl/sync_fifo_fwft_pkg.sv
// sfifo_pkg: shared constants and the width helper used by the FIFO slice.
package sfifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // ceil(log2(n)); works for any n >= 1, used for ADDR_W and CNT_W
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// sync_fifo_fwft_if: producer/consumer bus of the FIFO. The FIFO sits on the
// slave modport, the block driving it (or a bench) on the master modport.
interface sync_fifo_fwft_if
  import sfifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = clog2(16 + 1)
);

  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CNT_W-1:0]  af_thresh;
  logic [CNT_W-1:0]  ae_thresh;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  word_count;
  logic [CNT_W-1:0]  high_water;

  modport master (
    output clr, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           overflow, underflow, word_count, high_water
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           overflow, underflow, word_count, high_water
  );

endinterface

// File: rtl/sync_fifo_fwft_dpram.sv
// sfifo_dpram: 1W/1R storage, synchronous write, registered read with enable.
// The read register doubles as the FIFO output register, so it is reset and
// flushed; the array itself is never cleared.
module sfifo_dpram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // storage write; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // read register: holds the last word read until the next enabled read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata_q <= '0;
    else if (clr_i) rdata_q <= '0;
    else if (re_i)  rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO, any DEPTH >= 2, standard or
// first-word-fall-through read, programmable almost flags, sticky errors.
// Optional feature macro: SFIFO_HWM_EN enables the high-water-mark register;
// without it high_water is tied to zero.
module sync_fifo_fwft
  import sfifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int FWFT   = FWFT_OFF
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_fwft_if.slave bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              full_w, empty_w;
  logic              wr_acc, rd_acc;
  logic              ram_re, vld_nxt;
  logic [DATA_W-1:0] ram_rdata;

  // explicit wrap so non-power-of-2 depths never address past the array
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_A) ? '0 : p + 1'b1;
  endfunction

  assign full_w = (cnt_q == DEPTH_C);

  // acceptance uses pre-edge flags only; nothing is accepted during a flush
  assign wr_acc = bus.wr_en & ~full_w  & ~bus.clr;
  assign rd_acc = bus.rd_en & ~empty_w & ~bus.clr;

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      logic [CNT_W-1:0] ram_cnt;
      // prefetch the head into the output register whenever it is free or
      // being popped and the RAM still holds words, so pops stream bubble-free
      always_comb begin
        ram_cnt = cnt_q - CNT_W'(vld_q);
        ram_re  = (ram_cnt != '0) && (!vld_q || rd_acc);
        vld_nxt = ram_re || (vld_q && !rd_acc);
      end
      assign empty_w = ~vld_q;
    end else begin : g_std
      // standard mode: a read fetches straight from RAM, valid for one cycle
      always_comb begin
        ram_re  = rd_acc;
        vld_nxt = rd_acc;
      end
      assign empty_w = (cnt_q == '0);
    end
  endgenerate

  // next-state for pointers, occupancy, valid and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      vld_d    = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (ram_re) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      vld_d = vld_nxt;
      if (bus.wr_en && full_w)  ovf_d = 1'b1;
      if (bus.rd_en && empty_w) unf_d = 1'b1;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sfifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bus.clr),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

`ifdef SFIFO_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  // track the largest post-edge occupancy since reset or flush
  always_comb begin
    hwm_d = hwm_q;
    if (bus.clr)           hwm_d = '0;
    else if (cnt_d > hwm_q) hwm_d = cnt_d;
  end

  // high-water register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign bus.high_water = hwm_q;
`else
  assign bus.high_water = '0;
`endif

  assign bus.rd_data      = ram_rdata;
  assign bus.rd_valid     = vld_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt_q >= bus.af_thresh);
  assign bus.almost_empty = (cnt_q <= bus.ae_thresh);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
  assign bus.word_count   = cnt_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: drives a standard FIFO (DEPTH=16) and a FWFT FIFO
// (DEPTH=5) with shared traffic and checks both against a queue-level model.
module tb_sync_fifo_fwft;
  import sfifo_pkg::*;

  logic       clk, rst_n, clr, wr_en, rd_en;
  logic [7:0] wr_data;
  logic [4:0] af_t [2];
  logic [4:0] ae_t [2];
  int ntest, nfail;

  sync_fifo_fwft_if #(.DATA_W(8), .CNT_W(5)) if0 ();
  sync_fifo_fwft_if #(.DATA_W(8), .CNT_W(3)) if1 ();

  sync_fifo_fwft #(.DATA_W(8), .DEPTH(16), .FWFT(FWFT_OFF)) u_std (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  sync_fifo_fwft #(.DATA_W(8), .DEPTH(5), .FWFT(FWFT_ON)) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.clr = clr;          assign if1.clr = clr;
  assign if0.wr_en = wr_en;      assign if1.wr_en = wr_en;
  assign if0.wr_data = wr_data;  assign if1.wr_data = wr_data;
  assign if0.rd_en = rd_en;      assign if1.rd_en = rd_en;
  assign if0.af_thresh = af_t[0];
  assign if0.ae_thresh = ae_t[0];
  assign if1.af_thresh = af_t[1][2:0];
  assign if1.ae_thresh = ae_t[1][2:0];

  logic [7:0] o_rd [2];
  logic       o_vld [2], o_full [2], o_empty [2], o_af [2], o_ae [2], o_ovf [2], o_unf [2];
  logic [4:0] o_wc [2], o_hwm [2];

  assign o_rd[0] = if0.rd_data;        assign o_rd[1] = if1.rd_data;
  assign o_vld[0] = if0.rd_valid;      assign o_vld[1] = if1.rd_valid;
  assign o_full[0] = if0.full;         assign o_full[1] = if1.full;
  assign o_empty[0] = if0.empty;       assign o_empty[1] = if1.empty;
  assign o_af[0] = if0.almost_full;    assign o_af[1] = if1.almost_full;
  assign o_ae[0] = if0.almost_empty;   assign o_ae[1] = if1.almost_empty;
  assign o_ovf[0] = if0.overflow;      assign o_ovf[1] = if1.overflow;
  assign o_unf[0] = if0.underflow;     assign o_unf[1] = if1.underflow;
  assign o_wc[0] = if0.word_count;     assign o_wc[1] = {2'b00, if1.word_count};
  assign o_hwm[0] = if0.high_water;    assign o_hwm[1] = {2'b00, if1.high_water};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depth_of(input int d);
    return (d == 0) ? 16 : 5;
  endfunction

  function automatic bit fwft_of(input int d);
    return (d == 1);
  endfunction

  // reference model: contents as a queue, plus visible-head flag and stickies
  logic [7:0] mq [2][$];
  logic [7:0] sb [2][$];
  bit         mvis [2], movf [2], munf [2];
  int         mhwm [2];
  logic [7:0] mdat [2];

  task automatic model_clear(input int d);
    mq[d].delete();
    sb[d].delete();
    mvis[d] = 1'b0;
    movf[d] = 1'b0;
    munf[d] = 1'b0;
    mhwm[d] = 0;
    mdat[d] = 8'h00;
  endtask

  task automatic model_step(input int d);
    int sz;
    bit wok, rok;
    logic [7:0] w;
    sz  = mq[d].size();
    wok = wr_en && (sz < depth_of(d));
    rok = rd_en && (fwft_of(d) ? mvis[d] : (sz > 0));
    if (wr_en && !wok) movf[d] = 1'b1;
    if (rd_en && !rok) munf[d] = 1'b1;
    // FWFT: a word is presented one edge after it was stored
    mvis[d] = fwft_of(d) ? ((sz - int'(rok)) > 0) : rok;
    if (rok) begin
      w = mq[d].pop_front();
      if (!fwft_of(d)) mdat[d] = w;
    end
    if (wok) begin
      mq[d].push_back(wr_data);
      sb[d].push_back(wr_data);
    end
    if (mq[d].size() > mhwm[d]) mhwm[d] = mq[d].size();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) model_clear(d);
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (clr) model_clear(d);
        else     model_step(d);
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d: got %0h, want %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // monitor: flags against the model each cycle, data against the scoreboard
  always @(negedge clk) begin
    int sz;
    logic [7:0] e;
    for (int d = 0; d < 2; d++) begin
      sz = mq[d].size();
      chk("word_count", d, 32'(o_wc[d]), 32'(sz));
      chk("full", d, 32'(o_full[d]), 32'(sz == depth_of(d)));
      chk("empty", d, 32'(o_empty[d]), 32'(fwft_of(d) ? !mvis[d] : (sz == 0)));
      chk("almost_full", d, 32'(o_af[d]), 32'(sz >= int'(af_t[d])));
      chk("almost_empty", d, 32'(o_ae[d]), 32'(sz <= int'(ae_t[d])));
      chk("overflow", d, 32'(o_ovf[d]), 32'(movf[d]));
      chk("underflow", d, 32'(o_unf[d]), 32'(munf[d]));
      chk("rd_valid", d, 32'(o_vld[d]), 32'(mvis[d]));
`ifdef SFIFO_HWM_EN
      chk("high_water", d, 32'(o_hwm[d]), 32'(mhwm[d]));
`else
      chk("high_water", d, 32'(o_hwm[d]), 32'd0);
`endif
      if (!fwft_of(d)) chk("rd_data_hold", d, 32'(o_rd[d]), 32'(mdat[d]));
      if (o_vld[d] && (!fwft_of(d) || (rd_en && !clr && rst_n))) begin
        if (sb[d].size() == 0) begin
          chk("sb_underrun", d, 32'(o_rd[d]), 32'hFFFF_FFFF);
        end else begin
          e = sb[d].pop_front();
          chk("rd_data", d, 32'(o_rd[d]), 32'(e));
        end
      end
    end
  end

  task automatic cyc(input bit w, input logic [7:0] dat, input bit r);
    wr_en   = w;
    wr_data = dat;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pw, pr, bias;
    ntest = 0; nfail = 0;
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    af_t[0] = 5'd12; ae_t[0] = 5'd2; af_t[1] = 5'd4; ae_t[1] = 5'd1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // fill past full, then drain past empty
    for (int i = 1; i <= 17; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);

    // flush with traffic in the flush cycle
    clr = 1'b1; cyc(1'b1, 8'h55, 1'b1); clr = 1'b0;

    // single word fall-through then pop
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // wrap: three deep, then simultaneous traffic, then drain
    af_t[0] = 5'd4; ae_t[0] = 5'd1; af_t[1] = 5'd4; ae_t[1] = 5'd1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);

    // threshold sweep 0..5 and a flush while populated
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0);
    cyc(1'b1, 8'h70, 1'b0);
    clr = 1'b1; cyc(1'b0, 8'h00, 1'b0); clr = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);

    // randomized traffic with phase-biased fill/drain, flushes and a reset
    bias = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = int'($urandom_range(0, 2));
      pw = (bias == 0) ? 75 : (bias == 1) ? 25 : 50;
      pr = 100 - pw;
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) begin
        af_t[0] = 5'($urandom_range(0, 17));
        ae_t[0] = 5'($urandom_range(0, 17));
        af_t[1] = 5'($urandom_range(0, 7));
        ae_t[1] = 5'($urandom_range(0, 7));
      end
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
    end
    clr = 1'b0;
    repeat (4) cyc(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
